mccpu_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset CPU. It reuses the single-cycle datapath signal encodings (ALUOp, NPCOp, GPRSel, WDSel, EXTOp, ALUSrc) and sequences each instruction through IDLE/FETCH/DECODE/EXE/MEM/WB states. It handshakes with variable-latency instruction and data memories, and includes a wait-state watchdog. It sits between the IR (Op/Funct), ALU Zero flag, memories and the shared datapath.

---
 rtl/mccpu_ctrl_if.sv | 25 ++
 rtl/mccpu_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mccpu_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mccpu_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories.
interface mccpu_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic MemWrite;

    modport master (
        output imem_req,
        output dmem_req,
        output MemWrite,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  MemWrite,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS-subset control FSM with variable-latency memory handshake
// and a wait-state watchdog; strobes are decoded combinationally from state.
module mccpu_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [5:0]   Op,
    input  logic [5:0]   Funct,
    input  logic         Zero,
    mccpu_ctrl_if.master mem,
    output logic         IRWrite,
    output logic         PCWrite,
    output logic         RegWrite,
    output logic         EXTOp,
    output logic [2:0]   ALUOp,
    output logic [1:0]   NPCOp,
    output logic         ALUSrc,
    output logic [1:0]   GPRSel,
    output logic [1:0]   WDSel,
    output logic [2:0]   state,
    output logic         illegal,
    output logic         bus_err
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExe    = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd7
    } state_e;

    localparam logic [2:0] AluNop  = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluAnd  = 3'b011;
    localparam logic [2:0] AluOr   = 3'b100;
    localparam logic [2:0] AluSlt  = 3'b101;
    localparam logic [2:0] AluSltu = 3'b110;
    localparam logic [2:0] AluNor  = 3'b111;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                illegal_q, bus_err_q;
    logic                set_illegal, set_bus_err;

    logic       is_alu_r, is_jr, is_jalr;
    logic       is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic       is_legal, is_jump;
    logic [2:0] alu_r, alu_sel;
    logic       ext_sel, src_sel;

    always_comb begin
        is_alu_r = 1'b0;
        is_jr    = 1'b0;
        is_jalr  = 1'b0;
        alu_r    = AluNop;
        if (Op == 6'b000000) begin
            case (Funct)
                6'b100000, 6'b100001: begin is_alu_r = 1'b1; alu_r = AluAdd;  end
                6'b100010, 6'b100011: begin is_alu_r = 1'b1; alu_r = AluSub;  end
                6'b100100:            begin is_alu_r = 1'b1; alu_r = AluAnd;  end
                6'b100101:            begin is_alu_r = 1'b1; alu_r = AluOr;   end
                6'b100111:            begin is_alu_r = 1'b1; alu_r = AluNor;  end
                6'b101010:            begin is_alu_r = 1'b1; alu_r = AluSlt;  end
                6'b101011:            begin is_alu_r = 1'b1; alu_r = AluSltu; end
                6'b001000:            is_jr   = 1'b1;
                6'b001001:            is_jalr = 1'b1;
                default:              ;
            endcase
        end
    end

    assign is_addi  = (Op == 6'b001000);
    assign is_ori   = (Op == 6'b001101);
    assign is_lw    = (Op == 6'b100011);
    assign is_sw    = (Op == 6'b101011);
    assign is_beq   = (Op == 6'b000100);
    assign is_bne   = (Op == 6'b000101);
    assign is_j     = (Op == 6'b000010);
    assign is_jal   = (Op == 6'b000011);
    assign is_jump  = is_j | is_jal | is_jr | is_jalr;
    assign is_legal = is_alu_r | is_jump | is_addi | is_ori | is_lw | is_sw | is_beq | is_bne;

    // ALU setup shared by EXE and MEM so the address stays stable during the access
    always_comb begin
        if (is_alu_r)                       alu_sel = alu_r;
        else if (is_addi | is_lw | is_sw)   alu_sel = AluAdd;
        else if (is_ori)                    alu_sel = AluOr;
        else if (is_beq | is_bne)           alu_sel = AluSub;
        else                                alu_sel = AluNop;
    end
    assign ext_sel = is_addi | is_lw | is_sw;
    assign src_sel = is_addi | is_ori | is_lw | is_sw;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        set_illegal  = 1'b0;
        set_bus_err  = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.MemWrite = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        EXTOp        = 1'b0;
        ALUOp        = AluNop;
        NPCOp        = 2'b00;
        ALUSrc       = 1'b0;
        GPRSel       = 2'b00;
        WDSel        = 2'b00;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    IRWrite = 1'b1;
                    state_d = StDecode;
                end else if (cnt_q == WAIT_W'(MAX_WAIT)) begin
                    state_d     = StHalt;
                    set_bus_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDecode: begin
                if (!is_legal) begin
                    state_d     = StHalt;
                    set_illegal = 1'b1;
                end else if (is_jump) begin
                    PCWrite = 1'b1;
                    NPCOp   = (is_jr | is_jalr) ? 2'b11 : 2'b10;
                    if (is_jal | is_jalr) begin
                        RegWrite = 1'b1;
                        GPRSel   = 2'b10;
                        WDSel    = 2'b10;
                    end
                    state_d = StFetch;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                ALUOp  = alu_sel;
                EXTOp  = ext_sel;
                ALUSrc = src_sel;
                if (is_beq | is_bne) begin
                    PCWrite = 1'b1;
                    NPCOp   = ((is_beq & Zero) | (is_bne & ~Zero)) ? 2'b01 : 2'b00;
                    state_d = StFetch;
                end else if (is_lw | is_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                ALUOp        = alu_sel;
                EXTOp        = ext_sel;
                ALUSrc       = src_sel;
                mem.dmem_req = 1'b1;
                mem.MemWrite = is_sw;
                if (mem.dmem_ready) begin
                    if (is_sw) begin
                        PCWrite = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (cnt_q == WAIT_W'(MAX_WAIT)) begin
                    state_d     = StHalt;
                    set_bus_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWb: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                if (is_lw) begin
                    GPRSel = 2'b01;
                    WDSel  = 2'b01;
                end else if (is_addi | is_ori) begin
                    GPRSel = 2'b01;
                end
                state_d = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase

        // Every state change restarts the wait count for the next wait state
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_q | set_illegal;
            bus_err_q <= bus_err_q | set_bus_err;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Randomized self-checking bench for mccpu_ctrl: an instruction-level model
// predicts the per-cycle state, strobes and sticky flags.
module tb_mccpu_ctrl;
    localparam int MaxWait = 15;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc, illegal, bus_err;
    logic [2:0] ALUOp, state;
    logic [1:0] NPCOp, GPRSel, WDSel;

    mccpu_ctrl_if mif ();

    mccpu_ctrl #(.MAX_WAIT(MaxWait), .WAIT_W(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .mem      (mif),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .EXTOp    (EXTOp),
        .ALUOp    (ALUOp),
        .NPCOp    (NPCOp),
        .ALUSrc   (ALUSrc),
        .GPRSel   (GPRSel),
        .WDSel    (WDSel),
        .state    (state),
        .illegal  (illegal),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ext;
        logic [2:0] alu;
        logic [1:0] npc;
        logic       src;
        logic [1:0] gsel;
        logic [1:0] wdsel;
    } strobe_t;

    typedef enum int {KAluR, KJr, KJalr, KJ, KJal, KBeq, KBne, KAddi, KOri, KLw, KSw, KIll} kind_e;

    int   checks = 0;
    int   failures = 0;
    int   pc_pulses = 0;
    int   overlap = 0;
    logic exp_ill = 1'b0;
    logic exp_bus = 1'b0;
    logic [11:0] legal_tab [19];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic logic [21:0] observed();
        return {state, illegal, bus_err, mif.imem_req, mif.dmem_req, IRWrite, PCWrite, RegWrite,
                mif.MemWrite, EXTOp, ALUOp, NPCOp, ALUSrc, GPRSel, WDSel};
    endfunction

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b: return KAluR;
                    6'h08:   return KJr;
                    6'h09:   return KJalr;
                    default: return KIll;
                endcase
            end
            6'h08:   return KAddi;
            6'h0d:   return KOri;
            6'h23:   return KLw;
            6'h2b:   return KSw;
            6'h04:   return KBeq;
            6'h05:   return KBne;
            6'h02:   return KJ;
            6'h03:   return KJal;
            default: return KIll;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input kind_e k, input logic [5:0] fn);
        case (k)
            KAluR: begin
                case (fn)
                    6'h20, 6'h21: return 3'd1;
                    6'h22, 6'h23: return 3'd2;
                    6'h24:        return 3'd3;
                    6'h25:        return 3'd4;
                    6'h2a:        return 3'd5;
                    6'h2b:        return 3'd6;
                    6'h27:        return 3'd7;
                    default:      return 3'd0;
                endcase
            end
            KAddi, KLw, KSw: return 3'd1;
            KOri:            return 3'd4;
            KBeq, KBne:      return 3'd2;
            default:         return 3'd0;
        endcase
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance past the rising edge
    task automatic step(input string tag, input logic [2:0] st, input strobe_t s,
                        input logic irdy, input logic drdy, input logic z);
        logic [21:0] exp_v;
        mif.imem_ready = irdy;
        mif.dmem_ready = drdy;
        Zero = z;
        @(negedge clk);
        exp_v = {st, exp_ill, exp_bus, s};
        check_eq(tag, 32'(observed()), 32'(exp_v));
        pc_pulses += int'(PCWrite);
        if (RegWrite && mif.MemWrite) overlap++;
        @(posedge clk);
        #1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            Op = 6'($urandom);
            Funct = 6'($urandom);
            step("halt", 3'd7, '0, rnd(), rnd(), rnd());
        end
    endtask

    // Ready-low cycles; a wait longer than MaxWait expires into HALT
    task automatic wait_phase(input bit is_fetch, input logic [2:0] st, input int waits,
                              input strobe_t b, output bit expired);
        int n;
        expired = (waits > MaxWait);
        n = expired ? MaxWait + 1 : waits;
        for (int c = 0; c < n; c++) begin
            if (is_fetch) step("fetch_wait", st, b, 1'b0, rnd(), rnd());
            else          step("mem_wait", st, b, rnd(), 1'b0, rnd());
        end
    endtask

    task automatic do_reset();
        logic [21:0] zero_v;
        rstn = 1'b0;
        mif.imem_ready = rnd();
        mif.dmem_ready = rnd();
        #1;
        exp_ill = 1'b0;
        exp_bus = 1'b0;
        zero_v = '0;
        check_eq("reset", 32'(observed()), 32'(zero_v));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step("idle", 3'd0, '0, rnd(), rnd(), rnd());
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int iwait,
                             input int dwait, input logic z, input int mem_abort);
        kind_e   k;
        strobe_t s, b;
        bit      expired;
        k = classify(op, fn);
        pc_pulses = 0;
        Op = 6'($urandom);
        Funct = 6'($urandom);
        b = '0;
        b.imem_req = 1'b1;
        wait_phase(1'b1, 3'd1, iwait, b, expired);
        if (expired) begin
            exp_bus = 1'b1;
            halt_cycles(4);
            return;
        end
        s = b;
        s.irw = 1'b1;
        step("fetch", 3'd1, s, 1'b1, rnd(), rnd());
        Op = op;
        Funct = fn;

        s = '0;
        if (k == KIll) begin
            step("decode_ill", 3'd2, s, rnd(), rnd(), rnd());
            exp_ill = 1'b1;
            halt_cycles(20);
            return;
        end
        if (k == KJ || k == KJal || k == KJr || k == KJalr) begin
            s.pcw = 1'b1;
            s.npc = (k == KJr || k == KJalr) ? 2'b11 : 2'b10;
            if (k == KJal || k == KJalr) begin
                s.rw = 1'b1;
                s.gsel = 2'b10;
                s.wdsel = 2'b10;
            end
            step("decode_jmp", 3'd2, s, rnd(), rnd(), rnd());
            check_eq("pcw_once", pc_pulses, 1);
            return;
        end
        step("decode", 3'd2, s, rnd(), rnd(), rnd());

        s = '0;
        s.alu = alu_of(k, fn);
        s.ext = (k == KAddi || k == KLw || k == KSw);
        s.src = (k == KAddi || k == KOri || k == KLw || k == KSw);
        if (k == KBeq || k == KBne) begin
            s.pcw = 1'b1;
            s.npc = ((k == KBeq && z) || (k == KBne && !z)) ? 2'b01 : 2'b00;
            step("exe_br", 3'd3, s, rnd(), rnd(), z);
            check_eq("pcw_once", pc_pulses, 1);
            return;
        end
        step("exe", 3'd3, s, rnd(), rnd(), rnd());

        if (k == KLw || k == KSw) begin
            b = s;
            b.dmem_req = 1'b1;
            b.mw = (k == KSw);
            if (mem_abort >= 0) begin
                wait_phase(1'b0, 3'd4, mem_abort, b, expired);
                return;
            end
            wait_phase(1'b0, 3'd4, dwait, b, expired);
            if (expired) begin
                exp_bus = 1'b1;
                halt_cycles(4);
                return;
            end
            s = b;
            s.pcw = (k == KSw);
            step("mem", 3'd4, s, rnd(), 1'b1, rnd());
            if (k == KSw) begin
                check_eq("pcw_once", pc_pulses, 1);
                return;
            end
        end

        s = '0;
        s.rw = 1'b1;
        s.pcw = 1'b1;
        s.gsel = (k == KAluR) ? 2'b00 : 2'b01;
        s.wdsel = (k == KLw) ? 2'b01 : 2'b00;
        step("wb", 3'd5, s, rnd(), rnd(), rnd());
        check_eq("pcw_once", pc_pulses, 1);
    endtask

    task automatic pick_wait(output int w);
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) w = int'($urandom_range(0, 3));
        else        w = int'($urandom_range(MaxWait - 1, MaxWait + 2));
    endtask

    initial begin
        logic [11:0] ent;
        logic [5:0]  rop, rfn;
        int          iw, dw;
        legal_tab = '{
            {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24},
            {6'h00, 6'h25}, {6'h00, 6'h27}, {6'h00, 6'h2a}, {6'h00, 6'h2b}, {6'h00, 6'h08},
            {6'h00, 6'h09}, {6'h08, 6'h00}, {6'h0d, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00},
            {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}
        };
        rstn = 1'b0;
        Op = '0;
        Funct = '0;
        Zero = 1'b0;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        #12;
        do_reset();

        run_instr(6'h00, 6'h21, 0, 0, 1'b0, -1);   // addu
        run_instr(6'h23, 6'h15, 0, 3, 1'b0, -1);   // lw, 3 wait states
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, -1);   // beq taken
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, -1);   // beq not taken
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, -1);   // bne taken
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, -1);   // jal
        run_instr(6'h00, 6'h08, 0, 0, 1'b0, -1);   // jr
        run_instr(6'h2b, 6'h00, 1, 2, 1'b0, -1);   // sw
        run_instr(6'h3f, 6'h00, 0, 0, 1'b0, -1);   // illegal opcode
        do_reset();
        run_instr(6'h00, 6'h21, MaxWait + 1, 0, 1'b0, -1);  // imem watchdog expires
        do_reset();
        run_instr(6'h00, 6'h21, MaxWait, 0, 1'b0, -1);      // ready at the limit wins
        run_instr(6'h0d, 6'h00, MaxWait - 1, 0, 1'b0, -1);
        run_instr(6'h2b, 6'h00, 0, MaxWait + 1, 1'b0, -1);  // dmem watchdog expires
        do_reset();
        run_instr(6'h23, 6'h00, 0, MaxWait, 1'b0, -1);
        run_instr(6'h23, 6'h00, 0, 0, 1'b0, 2);             // abandon lw mid-MEM
        #2;
        rstn = 1'b0;
        #1;
        check_eq("async_dmem_req", 32'(mif.dmem_req), 32'd0);
        do_reset();

        for (int i = 0; i < 300; i++) begin
            if (int'($urandom_range(0, 99)) < 6) begin
                rop = 6'($urandom);
                rfn = 6'($urandom);
            end else begin
                ent = legal_tab[$urandom_range(0, 18)];
                rop = ent[11:6];
                rfn = (rop == 6'h00) ? ent[5:0] : 6'($urandom);
            end
            pick_wait(iw);
            pick_wait(dw);
            run_instr(rop, rfn, iw, dw, rnd(), -1);
            if (exp_ill || exp_bus) do_reset();
        end

        check_eq("rw_mw_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
